// File: rtl/wb_pkg.sv
// Shared types and helpers for the MEM->WB boundary.
//   WB_MAX_LANES : widest supported bundle
//   wb_lane_t    : per-lane writeback record at the default geometry
//   REG_ZERO     : the hard-wired zero register, never written
//   popcount     : number of set bits in a lane mask (up to WB_MAX_LANES)
package wb_pkg;

  localparam int WB_MAX_LANES = 4;
  localparam int WB_DW        = 32;
  localparam int WB_RW        = 5;

  typedef struct packed {
    logic             regwrite;
    logic             memtoreg;
    logic [WB_DW-1:0] readdata;
    logic [WB_DW-1:0] aluout;
    logic [WB_RW-1:0] writereg;
  } wb_lane_t;

  localparam logic [WB_RW-1:0] REG_ZERO = '0;

  function automatic logic [2:0] popcount(input logic [WB_MAX_LANES-1:0] v);
    logic [2:0] cnt;
    cnt = '0;
    for (int i = 0; i < WB_MAX_LANES; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/skid_buf2.sv
// Two-entry elastic buffer (main + skid) with synchronous flush.
//   clk_i, rst_n_i           : clock, async active-low reset
//   flush_i                  : drop both entries and any same-cycle input
//   in_valid_i / in_ready_o  : upstream handshake; ready depends on state only
//   in_data_i                : payload, W bits
//   out_valid_o / out_ready_i: downstream handshake, head is the main entry
//   out_data_o               : head payload
module skid_buf2 #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         flush_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         main_v_q, main_v_d, skid_v_q, skid_v_d;
  logic [W-1:0] main_q, main_d, skid_q, skid_d;
  logic         pop, push;

  assign in_ready_o  = ~skid_v_q;
  assign out_valid_o = main_v_q;
  assign out_data_o  = main_q;

  assign pop  = main_v_q & out_ready_i;
  assign push = in_valid_i & ~skid_v_q;

  always_comb begin
    main_v_d = main_v_q;
    main_d   = main_q;
    skid_v_d = skid_v_q;
    skid_d   = skid_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (pop) begin
      // push cannot coincide with a valid skid, so the skid always drains first
      if (skid_v_q) begin
        main_d   = skid_q;
        skid_v_d = 1'b0;
      end else if (push) begin
        main_d = in_data_i;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (push) begin
      if (!main_v_q) begin
        main_v_d = 1'b1;
        main_d   = in_data_i;
      end else begin
        skid_v_d = 1'b1;
        skid_d   = in_data_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      main_q   <= '0;
      skid_q   <= '0;
    end else begin
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
      main_q   <= main_d;
      skid_q   <= skid_d;
    end
  end

endmodule

// File: rtl/writeback_stage_buf.sv
// N-lane MEM->WB boundary: elastic skid-buffered bundle register, per-lane
// kill, writeback result mux, same-bundle register conflict resolution and
// retired-lane counter.
//   clk, reset (async active-low)
//   in_*   : bundle from the memory stage, lane i at [i*W +: W]
//   flush  : squash all buffered bundles and the same-cycle input
//   out_*  : register-file write ports (qualify with out_valid & out_ready)
//   retire_count : lanes committed since reset, wraps modulo 2^CW
module writeback_stage_buf
  import wb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int RW    = 5,
  parameter int CW    = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES-1:0]    in_lane_valid,
  input  logic [LANES-1:0]    in_kill,
  input  logic [LANES-1:0]    in_regwrite,
  input  logic [LANES-1:0]    in_memtoreg,
  input  logic [LANES*DW-1:0] in_readdata,
  input  logic [LANES*DW-1:0] in_aluout,
  input  logic [LANES*RW-1:0] in_writereg,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES-1:0]    out_we,
  output logic [LANES*RW-1:0] out_waddr,
  output logic [LANES*DW-1:0] out_wdata,
  output logic [CW-1:0]       retire_count
);

  typedef struct packed {
    logic          regwrite;
    logic          memtoreg;
    logic [DW-1:0] readdata;
    logic [DW-1:0] aluout;
    logic [RW-1:0] writereg;
  } lane_t;

  localparam int PW = LANES + LANES * $bits(lane_t);

  lane_t [LANES-1:0] in_lanes, head_lanes;
  logic  [LANES-1:0] in_lv, head_lv, we_raw;
  logic  [PW-1:0]    head_data;
  logic  [WB_MAX_LANES-1:0] lv_ext;
  logic  [CW-1:0]    retire_q, retire_d;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      in_lanes[i].regwrite = in_regwrite[i];
      in_lanes[i].memtoreg = in_memtoreg[i];
      in_lanes[i].readdata = in_readdata[i*DW +: DW];
      in_lanes[i].aluout   = in_aluout[i*DW +: DW];
      in_lanes[i].writereg = in_writereg[i*RW +: RW];
    end
  end

  // Killed lanes are stored as invalid; a bundle with no live lane is
  // accepted upstream but never allocates an entry.
  assign in_lv = in_lane_valid & ~in_kill;

  skid_buf2 #(.W(PW)) u_buf (
    .clk_i       (clk),
    .rst_n_i     (reset),
    .flush_i     (flush),
    .in_valid_i  (in_valid & (|in_lv)),
    .in_ready_o  (in_ready),
    .in_data_i   ({in_lv, in_lanes}),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (head_data)
  );

  assign head_lv    = head_data[PW-1 -: LANES];
  assign head_lanes = head_data[PW-LANES-1:0];

  always_comb begin
    we_raw    = '0;
    out_waddr = '0;
    out_wdata = '0;
    for (int i = 0; i < LANES; i++) begin
      out_waddr[i*RW +: RW] = head_lanes[i].writereg;
      out_wdata[i*DW +: DW] = head_lanes[i].memtoreg ? head_lanes[i].readdata
                                                     : head_lanes[i].aluout;
      we_raw[i] = out_valid & head_lv[i] & head_lanes[i].regwrite &
                  (head_lanes[i].writereg != RW'(REG_ZERO));
    end
  end

  // The youngest lane writing a register wins; older writes are suppressed.
  always_comb begin
    out_we = we_raw;
    for (int i = 0; i < LANES; i++) begin
      for (int j = i + 1; j < LANES; j++) begin
        if (we_raw[j] && (head_lanes[j].writereg == head_lanes[i].writereg)) begin
          out_we[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    lv_ext = '0;
    lv_ext[LANES-1:0] = head_lv;
    retire_d = retire_q;
    // A pop in the flush cycle still retires the head bundle.
    if (out_valid && out_ready) begin
      retire_d = retire_q + CW'(popcount(lv_ext));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
    end else begin
      retire_q <= retire_d;
    end
  end

  assign retire_count = retire_q;

endmodule
